// File: rtl/frame_buf_pkg.sv
// Shared widths, default frame geometry and bank helpers for the frame-bank arbiter.
// The state check is shared by the arbiter assertions and the testbench.
package frame_buf_pkg;

  localparam int BANK_W      = 2;
  localparam int ADDR_W      = 22;
  localparam int FRAME_WORDS = 384000;  // 800 x 480

  typedef logic [BANK_W-1:0] bank_t;

  // A bank's base address: bank index in the top bits, zeros below.
  function automatic logic [ADDR_W-1:0] base_addr(input bank_t bank);
    return {bank, {(ADDR_W-BANK_W){1'b0}}};
  endfunction

  // Writer and reader never share a bank; a pending frame sits in a third bank.
  function automatic logic bank_state_ok(input bank_t wr, input bank_t rd,
                                         input bank_t ready, input logic ready_valid);
    return (wr != rd) && (!ready_valid || ((ready != wr) && (ready != rd)));
  endfunction

endpackage

// File: rtl/free_bank_pick.sv
// Combinational round-robin search: first bank after cur (mod NUM_BANKS)
// that is neither excl_a nor excl_b.
module free_bank_pick #(
  parameter int NUM_BANKS = 3,
  parameter int BANK_W    = 2
) (
  input  logic [BANK_W-1:0] cur,
  input  logic [BANK_W-1:0] excl_a,
  input  logic [BANK_W-1:0] excl_b,
  output logic [BANK_W-1:0] pick,
  output logic              found
);

  int cand;

  // NOTE: every combinational output gets a default before the search so no latch is inferred.
  always_comb begin
    pick  = cur;
    found = 1'b0;
    cand  = 0;
    for (int i = 1; i < NUM_BANKS; i++) begin
      cand = int'(cur) + i;
      if (cand >= NUM_BANKS) cand = cand - NUM_BANKS;
      if (!found && (BANK_W'(cand) != excl_a) && (BANK_W'(cand) != excl_b)) begin
        pick  = BANK_W'(cand);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_bank_arbiter.sv
// Latest-frame triple/quad buffering for the camera -> SDRAM -> LCD path: the writer
// never touches the displayed bank and the reader always takes the newest complete frame.
module frame_bank_arbiter
  import frame_buf_pkg::*;
#(
  parameter int NUM_BANKS   = 3,
  parameter int BANK_W      = frame_buf_pkg::BANK_W,
  parameter int ADDR_W      = frame_buf_pkg::ADDR_W,
  parameter int FRAME_WORDS = frame_buf_pkg::FRAME_WORDS,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bank_valid,
  input  logic              frame_write_done,
  input  logic              frame_read_done,
  output logic [BANK_W-1:0] wr_bank,
  output logic [BANK_W-1:0] rd_bank,
  output logic              wr_load,
  output logic              rd_load,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] wr_max_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] rd_max_addr,
  output logic              ready_valid,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  repeat_cnt
);

  if ((NUM_BANKS < 3) || (NUM_BANKS > 4)) begin : g_bad_num_banks
    $error("frame_bank_arbiter: NUM_BANKS must be 3 or 4");
  end
  if ((1 << BANK_W) < NUM_BANKS) begin : g_bad_bank_w
    $error("frame_bank_arbiter: BANK_W too narrow for NUM_BANKS");
  end
  if (FRAME_WORDS >= (1 << (ADDR_W - BANK_W))) begin : g_bad_frame_words
    $error("frame_bank_arbiter: FRAME_WORDS overflows one bank");
  end

  logic [BANK_W-1:0] wr_q, rd_q, ready_q;
  logic              ready_valid_q;
  logic              wr_done_q, rd_done_q;
  logic [CNT_W-1:0]  drop_q, repeat_q;

  logic              wr_evt, rd_evt;
  logic [BANK_W-1:0] rd_n, wr_n, ready_n, pick;
  logic              rv_mid, rv_n, pick_found;
  logic [CNT_W-1:0]  drop_n, repeat_n;

  // A held-high done input produces a single event.
  assign wr_evt = frame_write_done & ~wr_done_q;
  assign rd_evt = frame_read_done  & ~rd_done_q;

  // The read resolves first against pre-event state.
  always_comb begin
    rd_n     = rd_q;
    rv_mid   = ready_valid_q;
    repeat_n = repeat_q;
    if (rd_evt) begin
      if (ready_valid_q) begin
        rd_n   = ready_q;
        rv_mid = 1'b0;
      end else begin
        repeat_n = repeat_q + CNT_W'(1);
      end
    end
  end

  // The just-written bank becomes the ready bank, so it is excluded alongside the new reader.
  free_bank_pick #(
    .NUM_BANKS (NUM_BANKS),
    .BANK_W    (BANK_W)
  ) u_pick (
    .cur    (wr_q),
    .excl_a (rd_n),
    .excl_b (wr_q),
    .pick   (pick),
    .found  (pick_found)
  );

  // A frame consumed by a same-cycle read is not counted as dropped.
  always_comb begin
    wr_n    = wr_q;
    ready_n = ready_q;
    rv_n    = rv_mid;
    drop_n  = drop_q;
    if (wr_evt && bank_valid) begin
      if (rv_mid) drop_n = drop_q + CNT_W'(1);
      ready_n = wr_q;
      rv_n    = 1'b1;
      wr_n    = pick;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q          <= BANK_W'(0);
      rd_q          <= BANK_W'(1);
      ready_q       <= BANK_W'(2);
      ready_valid_q <= 1'b0;
      wr_done_q     <= 1'b0;
      rd_done_q     <= 1'b0;
      wr_load       <= 1'b0;
      rd_load       <= 1'b0;
      drop_q        <= '0;
      repeat_q      <= '0;
    end else begin
      wr_q          <= wr_n;
      rd_q          <= rd_n;
      ready_q       <= ready_n;
      ready_valid_q <= rv_n;
      wr_done_q     <= frame_write_done;
      rd_done_q     <= frame_read_done;
      wr_load       <= wr_evt;
      rd_load       <= rd_evt;
      drop_q        <= drop_n;
      repeat_q      <= repeat_n;
    end
  end

  assign wr_bank     = wr_q;
  assign rd_bank     = rd_q;
  assign ready_valid = ready_valid_q;
  assign drop_cnt    = drop_q;
  assign repeat_cnt  = repeat_q;

  assign wr_addr     = {wr_q, {(ADDR_W-BANK_W){1'b0}}};
  assign rd_addr     = {rd_q, {(ADDR_W-BANK_W){1'b0}}};
  assign wr_max_addr = wr_addr + ADDR_W'(FRAME_WORDS);
  assign rd_max_addr = rd_addr + ADDR_W'(FRAME_WORDS);

  a_state_ok: assert property (@(posedge clk) disable iff (rst)
    bank_state_ok(bank_t'(wr_q), bank_t'(rd_q), bank_t'(ready_q), ready_valid_q));

  a_pick_found: assert property (@(posedge clk) disable iff (rst)
    (wr_evt && bank_valid) |-> pick_found);

endmodule

// File: tb/tb_frame_bank_arbiter.sv
// Directed bench driving a 3-bank and a 4-bank arbiter with identical stimulus;
// expected banks, addresses and counters are hand-computed per instance.
module tb_frame_bank_arbiter;
  import frame_buf_pkg::*;

  logic clk;
  logic rst;
  logic bank_valid;
  logic frame_write_done;
  logic frame_read_done;

  logic [1:0]  a_wr_bank, a_rd_bank, b_wr_bank, b_rd_bank;
  logic        a_wr_load, a_rd_load, b_wr_load, b_rd_load;
  logic [21:0] a_wr_addr, a_wr_max_addr, a_rd_addr, a_rd_max_addr;
  logic [21:0] b_wr_addr, b_wr_max_addr, b_rd_addr, b_rd_max_addr;
  logic        a_ready_valid, b_ready_valid;
  logic [15:0] a_drop_cnt, a_repeat_cnt, b_drop_cnt, b_repeat_cnt;

  int checks   = 0;
  int failures = 0;

  frame_bank_arbiter #(.NUM_BANKS(3)) u_dut3 (
    .clk              (clk),
    .rst              (rst),
    .bank_valid       (bank_valid),
    .frame_write_done (frame_write_done),
    .frame_read_done  (frame_read_done),
    .wr_bank          (a_wr_bank),
    .rd_bank          (a_rd_bank),
    .wr_load          (a_wr_load),
    .rd_load          (a_rd_load),
    .wr_addr          (a_wr_addr),
    .wr_max_addr      (a_wr_max_addr),
    .rd_addr          (a_rd_addr),
    .rd_max_addr      (a_rd_max_addr),
    .ready_valid      (a_ready_valid),
    .drop_cnt         (a_drop_cnt),
    .repeat_cnt       (a_repeat_cnt)
  );

  frame_bank_arbiter #(.NUM_BANKS(4)) u_dut4 (
    .clk              (clk),
    .rst              (rst),
    .bank_valid       (bank_valid),
    .frame_write_done (frame_write_done),
    .frame_read_done  (frame_read_done),
    .wr_bank          (b_wr_bank),
    .rd_bank          (b_rd_bank),
    .wr_load          (b_wr_load),
    .rd_load          (b_rd_load),
    .wr_addr          (b_wr_addr),
    .wr_max_addr      (b_wr_max_addr),
    .rd_addr          (b_rd_addr),
    .rd_max_addr      (b_rd_max_addr),
    .ready_valid      (b_ready_valid),
    .drop_cnt         (b_drop_cnt),
    .repeat_cnt       (b_repeat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // wa/ra: 3-bank instance, wb/rb: 4-bank instance; flags and counters are shared.
  task automatic expect_state(input string tag, input int wa, input int ra,
                              input int wb, input int rb, input int rv,
                              input int drop, input int rep);
    check({tag, " wr3"},   32'(a_wr_bank),     32'(wa));
    check({tag, " rd3"},   32'(a_rd_bank),     32'(ra));
    check({tag, " wr4"},   32'(b_wr_bank),     32'(wb));
    check({tag, " rd4"},   32'(b_rd_bank),     32'(rb));
    check({tag, " rv3"},   32'(a_ready_valid), 32'(rv));
    check({tag, " rv4"},   32'(b_ready_valid), 32'(rv));
    check({tag, " drop3"}, 32'(a_drop_cnt),    32'(drop));
    check({tag, " drop4"}, 32'(b_drop_cnt),    32'(drop));
    check({tag, " rep3"},  32'(a_repeat_cnt),  32'(rep));
    check({tag, " rep4"},  32'(b_repeat_cnt),  32'(rep));
  endtask

  // One rising edge on the chosen done inputs; loads must pulse for exactly one cycle.
  task automatic ev(input string tag, input logic w, input logic r);
    frame_write_done = w;
    frame_read_done  = r;
    @(negedge clk);
    check({tag, " wr_load3"}, 32'(a_wr_load), 32'(w));
    check({tag, " rd_load3"}, 32'(a_rd_load), 32'(r));
    check({tag, " wr_load4"}, 32'(b_wr_load), 32'(w));
    check({tag, " rd_load4"}, 32'(b_rd_load), 32'(r));
    frame_write_done = 1'b0;
    frame_read_done  = 1'b0;
    @(negedge clk);
    check({tag, " loads low"}, 32'({a_wr_load, a_rd_load, b_wr_load, b_rd_load}), 32'(0));
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    bank_valid       = 1'b1;
    frame_write_done = 1'b0;
    frame_read_done  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int pulses, changes, bad;
    logic [1:0] prev;

    do_reset();

    // Reset values, including addresses.
    expect_state("reset", 0, 1, 0, 1, 0, 0, 0);
    check("reset wr_addr",     32'(a_wr_addr),     32'h000000);
    check("reset wr_max_addr", 32'(a_wr_max_addr), 32'h05DC00);
    check("reset rd_addr",     32'(a_rd_addr),     32'h100000);
    check("reset rd_max_addr", 32'(b_rd_max_addr), 32'h15DC00);
    check("reset loads", 32'({a_wr_load, a_rd_load, b_wr_load, b_rd_load}), 32'(0));

    // Writer outruns reader: three writes, no reads.
    ev("w1", 1'b1, 1'b0);
    expect_state("w1", 2, 1, 2, 1, 1, 0, 0);
    ev("w2", 1'b1, 1'b0);
    expect_state("w2", 0, 1, 3, 1, 1, 1, 0);
    ev("w3", 1'b1, 1'b0);
    expect_state("w3", 2, 1, 0, 1, 1, 2, 0);

    // Steady alternation.
    do_reset();
    ev("alt w1", 1'b1, 1'b0);
    expect_state("alt w1", 2, 1, 2, 1, 1, 0, 0);
    check("alt w1 wr_max3", 32'(a_wr_max_addr), 32'(base_addr(2'd2)) + 32'(FRAME_WORDS));
    check("alt w1 wr_max4", 32'(b_wr_max_addr), 32'h25DC00);
    ev("alt r1", 1'b0, 1'b1);
    expect_state("alt r1", 2, 0, 2, 0, 0, 0, 0);
    check("alt r1 rd_addr3", 32'(a_rd_addr), 32'h000000);
    ev("alt w2", 1'b1, 1'b0);
    expect_state("alt w2", 1, 0, 3, 0, 1, 0, 0);
    check("alt w2 wr_max3", 32'(a_wr_max_addr), 32'h15DC00);
    check("alt w2 wr_max4", 32'(b_wr_max_addr), 32'h35DC00);
    ev("alt r2", 1'b0, 1'b1);
    expect_state("alt r2", 1, 2, 3, 2, 0, 0, 0);
    check("alt r2 rd_max4", 32'(b_rd_max_addr), 32'h25DC00);
    ev("alt w3", 1'b1, 1'b0);
    expect_state("alt w3", 0, 2, 0, 2, 1, 0, 0);
    check("alt w3 wr_max3", 32'(a_wr_max_addr), 32'h05DC00);
    ev("alt r3", 1'b0, 1'b1);
    expect_state("alt r3", 0, 1, 0, 3, 0, 0, 0);

    // Reads with nothing new: repeat the current frame.
    do_reset();
    ev("rep1", 1'b0, 1'b1);
    expect_state("rep1", 0, 1, 0, 1, 0, 0, 1);
    ev("rep2", 1'b0, 1'b1);
    expect_state("rep2", 0, 1, 0, 1, 0, 0, 2);

    // Simultaneous events from wr=0 rd=1 ready=2 (3-bank); 4-bank from wr=3 rd=1 ready=2.
    do_reset();
    ev("sim pre1", 1'b1, 1'b0);
    ev("sim pre2", 1'b1, 1'b0);
    expect_state("sim pre", 0, 1, 3, 1, 1, 1, 0);
    ev("sim", 1'b1, 1'b1);
    expect_state("sim", 1, 2, 0, 2, 1, 1, 0);
    check("sim ready3", 32'(u_dut3.ready_q), 32'(0));
    check("sim ready4", 32'(u_dut4.ready_q), 32'(3));

    // A held-high done input is one event.
    do_reset();
    pulses = 0;
    changes = 0;
    prev = a_wr_bank;
    frame_write_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_wr_load) pulses++;
      if (a_wr_bank != prev) changes++;
      prev = a_wr_bank;
    end
    frame_write_done = 1'b0;
    @(negedge clk);
    if (a_wr_load) pulses++;
    check("hold wr_load pulses", 32'(pulses), 32'(1));
    check("hold wr_bank changes", 32'(changes), 32'(1));
    expect_state("hold", 2, 1, 2, 1, 1, 0, 0);

    // Frames written while the source is invalid are discarded.
    do_reset();
    bank_valid = 1'b0;
    ev("inv1", 1'b1, 1'b0);
    expect_state("inv1", 0, 1, 0, 1, 0, 0, 0);
    bank_valid = 1'b1;
    ev("inv val", 1'b1, 1'b0);
    bank_valid = 1'b0;
    ev("inv2", 1'b1, 1'b0);
    expect_state("inv2", 2, 1, 2, 1, 1, 0, 0);
    bank_valid = 1'b1;

    // Reset mid-sequence wins over a coincident done edge and emits no load.
    do_reset();
    ev("mid r", 1'b0, 1'b1);
    ev("mid w", 1'b1, 1'b0);
    rst = 1'b1;
    frame_write_done = 1'b1;
    frame_read_done  = 1'b1;
    @(negedge clk);
    expect_state("mid rst", 0, 1, 0, 1, 0, 0, 0);
    check("mid rst loads", 32'({a_wr_load, a_rd_load, b_wr_load, b_rd_load}), 32'(0));
    check("mid rst wr_addr4", 32'(b_wr_addr), 32'h000000);
    frame_write_done = 1'b0;
    frame_read_done  = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Random done traffic; invariants must hold on both instances every cycle.
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      frame_write_done = 1'($urandom_range(0, 1));
      frame_read_done  = 1'($urandom_range(0, 1));
      bank_valid       = ($urandom_range(0, 7) != 0);
      @(negedge clk);
      if (!bank_state_ok(u_dut3.wr_q, u_dut3.rd_q, u_dut3.ready_q, u_dut3.ready_valid_q)) bad++;
      if (!bank_state_ok(u_dut4.wr_q, u_dut4.rd_q, u_dut4.ready_q, u_dut4.ready_valid_q)) bad++;
    end
    frame_write_done = 1'b0;
    frame_read_done  = 1'b0;
    check("random invariant violations", 32'(bad), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
